// File: rtl/pic_pkg.sv
// Shared FSM state encoding, 8080 CALL opcode and A0 command-word selects for the
// PIC processor-interface agent; also the strobe/gap counter width helper.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTA_LO,
    ST_INTA_HI,
    ST_DELIVER,
    ST_BUS_SETUP,
    ST_BUS_STROBE,
    ST_BUS_HOLD
  } pic_state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // A0 = 0 selects ICW1/OCW2/OCW3, A0 = 1 selects ICW2-4/OCW1.
  localparam logic A0_ICW1 = 1'b0;
  localparam logic A0_OCW2 = 1'b0;
  localparam logic A0_OCW3 = 1'b0;
  localparam logic A0_ICW2 = 1'b1;
  localparam logic A0_ICW3 = 1'b1;
  localparam logic A0_ICW4 = 1'b1;
  localparam logic A0_OCW1 = 1'b1;

  function automatic int cnt_width(input int pulse, input int gap);
    return $clog2(((pulse > gap) ? pulse : gap) + 1);
  endfunction

endpackage

// File: rtl/pic_sync2.sv
// Two-flop synchroniser bringing the controller's asynchronous INTERRUPT line into
// the clock domain; two clocks of latency, cleared by asynchronous reset.
module pic_sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pic_cpu_agent.sv
// CPU-side initiator for the PIC: runs INTA_n acknowledge sequences (8086 or 8080 style)
// and CS_n/RD_n/WR_n register cycles; the vector is held on vec_valid until vec_ready.
module pic_cpu_agent
  import pic_pkg::*;
#(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int MODE_8086    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        int_in,
  input  logic        int_enable,
  output logic        inta_n,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        a0,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic [7:0]  vec_data,
  output logic [15:0] call_addr,
  input  logic        host_req,
  input  logic        host_we,
  input  logic        host_a0,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        busy
);

  localparam int            CW         = cnt_width(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam bit            IS_8086    = (MODE_8086 != 0);
  localparam logic [1:0]    LAST_PULSE = IS_8086 ? 2'd2 : 2'd3;

  pic_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    pulse, pulse_nxt;
  logic          int_sync;
  logic          cnt_done;
  logic          bus_we;

  pic_sync2 u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (int_in),
    .q       (int_sync)
  );

  assign cnt_done = (cnt == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pulse <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
    end
  end

  // The counter is reloaded on every state entry and parks at zero otherwise.
  always_comb begin
    state_nxt = state;
    pulse_nxt = pulse;
    cnt_nxt   = cnt_done ? cnt : cnt - CW'(1);
    case (state)
      ST_IDLE: begin
        if (int_sync && int_enable && !vec_valid) begin
          state_nxt = ST_INTA_LO;
          pulse_nxt = 2'd1;
          cnt_nxt   = PULSE_LOAD;
        end else if (host_req) begin
          state_nxt = ST_BUS_SETUP;
          cnt_nxt   = '0;
        end
      end
      ST_INTA_LO: begin
        if (cnt_done) begin
          if (pulse == LAST_PULSE) begin
            state_nxt = ST_DELIVER;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_INTA_HI;
            cnt_nxt   = GAP_LOAD;
          end
        end
      end
      ST_INTA_HI: begin
        if (cnt_done) begin
          state_nxt = ST_INTA_LO;
          pulse_nxt = pulse + 2'd1;
          cnt_nxt   = PULSE_LOAD;
        end
      end
      ST_DELIVER: begin
        if (vec_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUS_SETUP: begin
        state_nxt = ST_BUS_STROBE;
        cnt_nxt   = PULSE_LOAD;
      end
      ST_BUS_STROBE: begin
        if (cnt_done) begin
          state_nxt = ST_BUS_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_BUS_HOLD: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    inta_n    = 1'b1;
    cs_n      = 1'b1;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    data_oe   = 1'b0;
    vec_valid = 1'b0;
    host_ack  = 1'b0;
    case (state)
      ST_INTA_LO: inta_n = 1'b0;
      ST_DELIVER: vec_valid = 1'b1;
      ST_BUS_SETUP: begin
        cs_n    = 1'b0;
        data_oe = bus_we;
      end
      ST_BUS_STROBE: begin
        cs_n    = 1'b0;
        rd_n    = bus_we;
        wr_n    = !bus_we;
        data_oe = bus_we;
      end
      ST_BUS_HOLD: begin
        cs_n     = 1'b0;
        data_oe  = bus_we;
        host_ack = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Bytes are sampled on the last low clock of each strobe, when the controller has settled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a0         <= 1'b0;
      data_out   <= 8'h00;
      bus_we     <= 1'b0;
      vec_data   <= 8'h00;
      call_addr  <= 16'h0000;
      host_rdata <= 8'h00;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_BUS_SETUP) begin
        a0     <= host_a0;
        bus_we <= host_we;
        if (host_we) begin
          data_out <= host_wdata;
        end
      end
      if (state == ST_INTA_LO && cnt_done) begin
        case (pulse)
          2'd1: if (!IS_8086) vec_data <= data_in;
          2'd2: begin
            if (IS_8086) vec_data <= data_in;
            else         call_addr[7:0] <= data_in;
          end
          2'd3: call_addr[15:8] <= data_in;
          default: ;
        endcase
      end
      if (state == ST_BUS_STROBE && cnt_done && !bus_we) begin
        host_rdata <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_pic_cpu_agent.sv
// Bench for pic_cpu_agent: an 8086-mode and an 8080-mode instance share clock and reset,
// each talking to a small behavioural controller model; a monitor scores against queues.
module tb_pic_cpu_agent;
  import pic_pkg::*;

  localparam int P = 2;
  localparam int G = 2;
  localparam logic [7:0] IRR = 8'h04;

  typedef struct { int d; logic [7:0] vec; logic [15:0] addr; } vexp_t;
  typedef struct { int d; logic we; logic [7:0] rdata; } hexp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [1:0]  int_in, int_enable, inta_n, cs_n, rd_n, wr_n, a0, data_oe;
  logic [1:0]  vec_valid, vec_ready, host_req, host_we, host_a0, host_ack, busy;
  logic [7:0]  data_out [2];
  logic [7:0]  data_in [2];
  logic [7:0]  vec_data [2];
  logic [7:0]  host_wdata [2];
  logic [7:0]  host_rdata [2];
  logic [15:0] call_addr [2];

  pic_cpu_agent #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .MODE_8086(1)) u_dut86 (
    .clock(clock), .reset_n(reset_n), .int_in(int_in[0]), .int_enable(int_enable[0]),
    .inta_n(inta_n[0]), .cs_n(cs_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]), .a0(a0[0]),
    .data_out(data_out[0]), .data_oe(data_oe[0]), .data_in(data_in[0]),
    .vec_valid(vec_valid[0]), .vec_ready(vec_ready[0]), .vec_data(vec_data[0]),
    .call_addr(call_addr[0]), .host_req(host_req[0]), .host_we(host_we[0]),
    .host_a0(host_a0[0]), .host_wdata(host_wdata[0]), .host_ack(host_ack[0]),
    .host_rdata(host_rdata[0]), .busy(busy[0])
  );

  pic_cpu_agent #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .MODE_8086(0)) u_dut80 (
    .clock(clock), .reset_n(reset_n), .int_in(int_in[1]), .int_enable(int_enable[1]),
    .inta_n(inta_n[1]), .cs_n(cs_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]), .a0(a0[1]),
    .data_out(data_out[1]), .data_oe(data_oe[1]), .data_in(data_in[1]),
    .vec_valid(vec_valid[1]), .vec_ready(vec_ready[1]), .vec_data(vec_data[1]),
    .call_addr(call_addr[1]), .host_req(host_req[1]), .host_we(host_we[1]),
    .host_a0(host_a0[1]), .host_wdata(host_wdata[1]), .host_ack(host_ack[1]),
    .host_rdata(host_rdata[1]), .busy(busy[1])
  );

  // Controller model: counts INTA pulses and serves the byte for the current pulse.
  int unsigned pulse_cnt [2] = '{0, 0};
  int unsigned seq_base [2];
  logic [7:0]  ack_byte [2][3];
  logic [7:0]  ctl_imr [2];

  always @(posedge inta_n[0]) pulse_cnt[0] <= pulse_cnt[0] + 1;
  always @(posedge inta_n[1]) pulse_cnt[1] <= pulse_cnt[1] + 1;

  for (genvar g = 0; g < 2; g++) begin : g_ctl
    assign data_in[g] = !inta_n[g] ? ack_byte[g][(pulse_cnt[g] - seq_base[g]) % 3] :
                        (!cs_n[g] && !rd_n[g]) ? (a0[g] ? ctl_imr[g] : IRR) : 8'hA5;
  end

  vexp_t vq[$];
  hexp_t hq[$];
  vexp_t mv;
  hexp_t mh;
  logic [7:0] ref_imr [2];
  logic [7:0] cur_wdata [2];
  int   lo_run [2], hi_run [2], cs_run [2], st_run [2];
  time  vec_time [2], ack_time [2];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int npulse(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        ctl_imr[d]  = 8'h00;
        seq_base[d] = pulse_cnt[d];
        lo_run[d] = 0; hi_run[d] = 0; cs_run[d] = 0; st_run[d] = 0;
      end else begin
        if (!cs_n[d] && !wr_n[d] && a0[d]) ctl_imr[d] = data_out[d];
        if (!(inta_n[d] && rd_n[d] && wr_n[d]))
          check($countones({inta_n[d], rd_n[d], wr_n[d]}) == 2, "strobe_excl",
                {inta_n[d], rd_n[d], wr_n[d]}, 3'b011);
        if (data_oe[d]) begin
          check(inta_n[d] && rd_n[d], "oe_vs_strobe", {inta_n[d], rd_n[d]}, 2'b11);
          check(data_out[d] == cur_wdata[d], "data_out_hold", data_out[d], cur_wdata[d]);
        end
        if (!inta_n[d]) begin
          if (lo_run[d] == 0 && pulse_cnt[d] != seq_base[d])
            check(hi_run[d] == G, "inta_gap", hi_run[d], G);
          lo_run[d]++;
          hi_run[d] = 0;
        end else begin
          if (lo_run[d] != 0) check(lo_run[d] == P, "inta_low", lo_run[d], P);
          lo_run[d] = 0;
          hi_run[d]++;
        end
        if (!cs_n[d]) cs_run[d]++;
        else begin
          if (cs_run[d] != 0) check(cs_run[d] == P + 2, "cs_low", cs_run[d], P + 2);
          cs_run[d] = 0;
        end
        if (!rd_n[d] || !wr_n[d]) st_run[d]++;
        else begin
          if (st_run[d] != 0) check(st_run[d] == P, "rdwr_low", st_run[d], P);
          st_run[d] = 0;
        end
        if (vec_valid[d] && vec_ready[d]) begin
          if (vq.size() == 0) check(1'b0, "vec_unexpected", vec_data[d], 0);
          else begin
            mv = vq.pop_front();
            check(mv.d == d, "vec_dut", d, mv.d);
            check(vec_data[d] == mv.vec, "vec_data", vec_data[d], mv.vec);
            check(call_addr[d] == mv.addr, "call_addr", call_addr[d], mv.addr);
            check(pulse_cnt[d] - seq_base[d] == npulse(d), "inta_pulses",
                  pulse_cnt[d] - seq_base[d], npulse(d));
          end
          seq_base[d] = pulse_cnt[d];
          vec_time[d] = $time;
        end
        if (host_ack[d]) begin
          if (hq.size() == 0) check(1'b0, "ack_unexpected", host_rdata[d], 0);
          else begin
            mh = hq.pop_front();
            check(mh.d == d, "ack_dut", d, mh.d);
            if (!mh.we) check(host_rdata[d] == mh.rdata, "host_rdata", host_rdata[d], mh.rdata);
          end
          ack_time[d] = $time;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_access(input int d, input logic we, input logic av, input logic [7:0] wd,
                             input bit chk_lat);
    hexp_t h;
    int n;
    h.d = d; h.we = we; h.rdata = av ? ref_imr[d] : IRR;
    if (we && av) ref_imr[d] = wd;
    hq.push_back(h);
    cur_wdata[d] = wd;
    host_we[d] = we; host_a0[d] = av; host_wdata[d] = wd; host_req[d] = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!host_ack[d] && n < 100);
    check(host_ack[d], "ack_timeout", n, 0);
    if (chk_lat) check(n == P + 3, "ack_latency", n, P + 3);
    tick();
    host_req[d] = 1'b0;
  endtask

  task automatic intr(input int d, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input int rdy_delay);
    vexp_t v;
    int n, np;
    np = npulse(d);
    ack_byte[d][0] = b0; ack_byte[d][1] = b1; ack_byte[d][2] = b2;
    v.d = d;
    v.vec  = (d == 0) ? b1 : b0;
    v.addr = (d == 0) ? 16'h0000 : {b2, b1};
    vq.push_back(v);
    vec_ready[d] = (rdy_delay == 0);
    int_in[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (!inta_n[d]) int_in[d] = 1'b0;
    end while (!vec_valid[d] && n < 200);
    check(vec_valid[d], "vec_timeout", n, 0);
    check(n == np * P + (np - 1) * G + 4, "vec_latency", n, np * P + (np - 1) * G + 4);
    for (int i = 1; i < rdy_delay; i++) begin
      @(negedge clock);
      check(vec_valid[d] && vec_data[d] == v.vec, "vec_hold", {vec_valid[d], vec_data[d]},
            {1'b1, v.vec});
    end
    if (rdy_delay > 0) begin
      tick();
      vec_ready[d] = 1'b1;
      @(negedge clock);
    end
    tick();
    vec_ready[d] = 1'b0;
    @(negedge clock);
    check(!vec_valid[d], "vec_drop", vec_valid[d], 0);
  endtask

  task automatic check_reset_state(input int d);
    check({inta_n[d], cs_n[d], rd_n[d], wr_n[d], data_oe[d], a0[d], vec_valid[d], host_ack[d],
           busy[d]} == 9'b111100000, "reset_ctl",
          {inta_n[d], cs_n[d], rd_n[d], wr_n[d], data_oe[d], a0[d], vec_valid[d], host_ack[d],
           busy[d]}, 9'b111100000);
    check({data_out[d], vec_data[d], host_rdata[d], call_addr[d]} == 40'h0, "reset_data",
          {data_out[d], vec_data[d], host_rdata[d], call_addr[d]}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int n, rd, rop;
    int unsigned snap;
    reset_n = 1'b0;
    int_in = '0; int_enable = 2'b11; vec_ready = '0;
    host_req = '0; host_we = '0; host_a0 = '0;
    host_wdata = '{8'h00, 8'h00};
    ref_imr = '{8'h00, 8'h00};
    cur_wdata = '{8'h00, 8'h00};
    repeat (3) @(negedge clock);
    check_reset_state(0);
    check_reset_state(1);
    tick();
    reset_n = 1'b1;

    tick(); host_access(0, 1'b1, A0_ICW1, 8'h13, 1'b1);
    tick(); host_access(0, 1'b1, A0_ICW2, 8'h20, 1'b1);
    tick(); intr(0, 8'hFF, 8'h25, 8'h00, 3);
    tick(); intr(1, CALL_OPCODE, 8'h40, 8'h12, 1);
    tick(); host_access(1, 1'b1, A0_OCW1, 8'h5A, 1'b1);
    tick(); host_access(1, 1'b0, A0_OCW1, 8'h00, 1'b1);

    // Interrupt and host request reach the arbiter in the same cycle.
    tick();
    fork
      intr(0, 8'hFF, 8'h31, 8'h00, 2);
      begin
        tick(); tick();
        host_access(0, 1'b1, A0_OCW2, 8'h60, 1'b0);
      end
    join
    check(ack_time[0] > vec_time[0], "prio_order", ack_time[0], vec_time[0]);

    int_enable[0] = 1'b0;
    int_in[0] = 1'b1;
    snap = pulse_cnt[0];
    repeat (10) @(negedge clock);
    tick(); host_access(0, 1'b0, A0_OCW3, 8'h00, 1'b1);
    tick(); host_access(0, 1'b0, A0_OCW1, 8'h00, 1'b1);
    check(pulse_cnt[0] == snap && inta_n[0], "inta_disabled", pulse_cnt[0] - snap, 0);
    int_in[0] = 1'b0;
    repeat (4) @(negedge clock);
    int_enable[0] = 1'b1;

    // Reset in the middle of the first acknowledge pulse.
    tick();
    ack_byte[0][0] = 8'hFF; ack_byte[0][1] = 8'h77; ack_byte[0][2] = 8'h00;
    int_in[0] = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (inta_n[0] && n < 50);
    check(!inta_n[0], "rst_inta_start", inta_n[0], 0);
    int_in[0] = 1'b0;
    #1 reset_n = 1'b0;
    #1 check(inta_n[0] && !vec_valid[0] && !busy[0], "rst_async",
             {inta_n[0], vec_valid[0], busy[0]}, 3'b100);
    check_reset_state(0);
    check_reset_state(1);
    ref_imr = '{8'h00, 8'h00};
    @(negedge clock);
    tick();
    reset_n = 1'b1;
    repeat (12) @(negedge clock);
    check(!vec_valid[0] && !busy[0], "rst_no_vec", {vec_valid[0], busy[0]}, 0);

    for (int it = 0; it < 40; it++) begin
      rd  = int'($urandom_range(0, 1));
      rop = int'($urandom_range(0, 2));
      tick();
      case (rop)
        0: host_access(rd, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
        1: host_access(rd, 1'b0, 1'($urandom_range(0, 1)), 8'h00, 1'b1);
        default: intr(rd, (rd == 1) ? CALL_OPCODE : 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 3)));
      endcase
    end

    repeat (4) @(negedge clock);
    check(vq.size() == 0, "vec_queue_empty", vq.size(), 0);
    check(hq.size() == 0, "ack_queue_empty", hq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
